// File: rtl/charmatrix_pkg.sv
// Shared types and widths for the character-matrix glyph path.
// Requester ids index req/gnt bit positions.
package charmatrix_pkg;

   localparam int unsigned GLYPH_W = 35;
   localparam int unsigned CODE_W  = 8;

   localparam logic REQ_DISPLAY = 1'b0;
   localparam logic REQ_SERIAL  = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      RESP  = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone request wins outright.
// When both ports request, the port not served last wins.
module rr_arb2
   import charmatrix_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       winner,
   output logic       any_req
);

   always_comb begin
      any_req = req[REQ_DISPLAY] | req[REQ_SERIAL];
      if (req[REQ_DISPLAY] && req[REQ_SERIAL]) begin
         winner = ~last;
      end else begin
         winner = req[REQ_SERIAL];
      end
   end

endmodule

// File: rtl/glyph_fetch_arb.sv
// Arbitrates the shared glyph ROM between the display scanner and the serial engine.
// The cycle is IDLE -> FETCH (gnt, registered ROM address) -> RESP (rvalid, tagged rdata).
module glyph_fetch_arb
   import charmatrix_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = GLYPH_W,
   parameter int unsigned ADDR_WIDTH = CODE_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            req,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   output logic [1:0]            gnt,
   output logic                  rvalid,
   output logic                  rid,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data
);

   arb_state_e            state_q, state_d;
   logic [1:0]            gnt_q, gnt_d;
   logic                  rvalid_q, rvalid_d;
   logic                  rid_q, rid_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  busy_q, busy_d;
   logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
   logic                  owner_q, owner_d;
   logic                  last_q, last_d;
   logic                  winner;
   logic                  any_req;

   rr_arb2 u_rr_arb2 (
      .req     (req),
      .last    (last_q),
      .winner  (winner),
      .any_req (any_req)
   );

   always_comb begin
      state_d    = state_q;
      gnt_d      = 2'b00;
      rvalid_d   = 1'b0;
      rid_d      = rid_q;
      rdata_d    = rdata_q;
      busy_d     = busy_q;
      rom_addr_d = rom_addr_q;
      owner_d    = owner_q;
      last_d     = last_q;
      unique case (state_q)
         IDLE, RESP: begin
            // RESP arbitrates like IDLE so back-to-back fetches skip the idle cycle.
            if (any_req) begin
               state_d    = FETCH;
               gnt_d      = 2'b01 << winner;
               rom_addr_d = winner ? addr1 : addr0;
               owner_d    = winner;
               last_d     = winner;
               busy_d     = 1'b1;
            end else begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         FETCH: begin
            state_d  = RESP;
            rdata_d  = rom_data;
            rid_d    = owner_q;
            rvalid_d = 1'b1;
            busy_d   = 1'b1;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         gnt_q      <= 2'b00;
         rvalid_q   <= 1'b0;
         rid_q      <= 1'b0;
         rdata_q    <= '0;
         busy_q     <= 1'b0;
         rom_addr_q <= '0;
         owner_q    <= 1'b0;
         last_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         rvalid_q   <= rvalid_d;
         rid_q      <= rid_d;
         rdata_q    <= rdata_d;
         busy_q     <= busy_d;
         rom_addr_q <= rom_addr_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
      end
   end

   assign gnt      = gnt_q;
   assign rvalid   = rvalid_q;
   assign rid      = rid_q;
   assign rdata    = rdata_q;
   assign busy     = busy_q;
   assign rom_addr = rom_addr_q;

endmodule

// File: tb/tb_glyph_fetch_arb.sv
// Directed bench for glyph_fetch_arb: per-cycle vector table plus hand-written
// fairness, hold and asynchronous-reset sequences against a behavioural ROM.
module tb_glyph_fetch_arb;
   import charmatrix_pkg::*;

   logic        clk;
   logic        rst;
   logic [1:0]  req;
   logic [7:0]  addr0;
   logic [7:0]  addr1;
   logic [1:0]  gnt;
   logic        rvalid;
   logic        rid;
   logic [34:0] rdata;
   logic        busy;
   logic [7:0]  rom_addr;
   logic [34:0] rom_data;

   int n_total = 0;
   int n_pass  = 0;

   function automatic logic [34:0] glyph(input logic [7:0] a);
      return {a[2:0], a, ~a, a, a};
   endfunction

   assign rom_data = glyph(rom_addr);

   glyph_fetch_arb #(
      .DATA_WIDTH (35),
      .ADDR_WIDTH (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .addr0    (addr0),
      .addr1    (addr1),
      .gnt      (gnt),
      .rvalid   (rvalid),
      .rid      (rid),
      .rdata    (rdata),
      .busy     (busy),
      .rom_addr (rom_addr),
      .rom_data (rom_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Expected outputs observed this cycle, then inputs driven for the next edge.
   typedef struct packed {
      logic [1:0]  e_gnt;
      logic        e_rv;
      logic        e_rid;
      logic [34:0] e_rdata;
      logic        e_busy;
      logic [7:0]  e_rom;
      logic [1:0]  req;
      logic [7:0]  a0;
      logic [7:0]  a1;
   } vec_t;

   function automatic vec_t mk(input logic [1:0] g, input logic rv, input logic id,
                               input logic [34:0] d, input logic b, input logic [7:0] ra,
                               input logic [1:0] r, input logic [7:0] x0, input logic [7:0] x1);
      vec_t v;
      v.e_gnt = g; v.e_rv = rv; v.e_rid = id; v.e_rdata = d; v.e_busy = b; v.e_rom = ra;
      v.req = r; v.a0 = x0; v.a1 = x1;
      return v;
   endfunction

   vec_t tv[13];

   initial begin
      tv[0]  = mk(2'b00, 0, 0, '0,           0, 8'h00, 2'b01, 8'h41, 8'h00);
      tv[1]  = mk(2'b01, 0, 0, '0,           1, 8'h41, 2'b00, 8'h41, 8'h00);
      tv[2]  = mk(2'b00, 1, 0, glyph(8'h41), 1, 8'h41, 2'b00, 8'h41, 8'h00);
      tv[3]  = mk(2'b00, 0, 0, glyph(8'h41), 0, 8'h41, 2'b10, 8'h41, 8'h55);
      tv[4]  = mk(2'b10, 0, 0, glyph(8'h41), 1, 8'h55, 2'b00, 8'h41, 8'h99);
      tv[5]  = mk(2'b00, 1, 1, glyph(8'h55), 1, 8'h55, 2'b11, 8'h30, 8'h31);
      tv[6]  = mk(2'b01, 0, 1, glyph(8'h55), 1, 8'h30, 2'b11, 8'h30, 8'h31);
      tv[7]  = mk(2'b00, 1, 0, glyph(8'h30), 1, 8'h30, 2'b11, 8'h30, 8'h31);
      tv[8]  = mk(2'b10, 0, 0, glyph(8'h30), 1, 8'h31, 2'b11, 8'h30, 8'h31);
      tv[9]  = mk(2'b00, 1, 1, glyph(8'h31), 1, 8'h31, 2'b01, 8'h30, 8'h31);
      tv[10] = mk(2'b01, 0, 1, glyph(8'h31), 1, 8'h30, 2'b00, 8'h30, 8'h31);
      tv[11] = mk(2'b00, 1, 0, glyph(8'h30), 1, 8'h30, 2'b00, 8'h30, 8'h31);
      tv[12] = mk(2'b00, 0, 0, glyph(8'h30), 0, 8'h30, 2'b00, 8'h30, 8'h31);

      rst = 1'b1; req = 2'b00; addr0 = 8'h00; addr1 = 8'h00;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 13; i++) begin
         chk($sformatf("v%0d gnt", i),      64'(gnt),      64'(tv[i].e_gnt));
         chk($sformatf("v%0d rvalid", i),   64'(rvalid),   64'(tv[i].e_rv));
         chk($sformatf("v%0d rid", i),      64'(rid),      64'(tv[i].e_rid));
         chk($sformatf("v%0d rdata", i),    64'(rdata),    64'(tv[i].e_rdata));
         chk($sformatf("v%0d busy", i),     64'(busy),     64'(tv[i].e_busy));
         chk($sformatf("v%0d rom_addr", i), 64'(rom_addr), 64'(tv[i].e_rom));
         req = tv[i].req; addr0 = tv[i].a0; addr1 = tv[i].a1;
         @(negedge clk);
      end

      // Fairness: req0 held, req1 raised once while port 0 is being served.
      req = 2'b01; addr0 = 8'h30; addr1 = 8'h31;
      @(negedge clk);
      chk("fair gnt0", 64'(gnt), 64'(2'b01));
      req = 2'b11;
      @(negedge clk);
      chk("fair rv0", 64'({rvalid, rid}), 64'(2'b10));
      @(negedge clk);
      chk("fair gnt1", 64'(gnt), 64'(2'b10));
      chk("fair busy", 64'(busy), 64'(1'b1));
      req = 2'b01;
      @(negedge clk);
      chk("fair rv1", 64'({rvalid, rid}), 64'(2'b11));
      chk("fair rdata1", 64'(rdata), 64'(glyph(8'h31)));
      @(negedge clk);
      chk("fair gnt0b", 64'(gnt), 64'(2'b01));
      req = 2'b00;
      @(negedge clk);
      chk("fair rv0b", 64'({rvalid, rid}), 64'(2'b10));
      chk("fair rdata0", 64'(rdata), 64'(glyph(8'h30)));
      @(negedge clk);
      chk("fair idle", 64'(busy), 64'(1'b0));

      // Hold: outputs stay put with no requests.
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk($sformatf("hold%0d rdata", c),    64'(rdata),    64'(glyph(8'h30)));
         chk($sformatf("hold%0d rid", c),      64'(rid),      64'(1'b0));
         chk($sformatf("hold%0d rom_addr", c), 64'(rom_addr), 64'(8'h30));
         chk($sformatf("hold%0d rvalid", c),   64'(rvalid),   64'(1'b0));
         chk($sformatf("hold%0d gnt", c),      64'(gnt),      64'(2'b00));
      end

      // Asynchronous reset in the middle of a fetch.
      req = 2'b10; addr1 = 8'h77;
      @(negedge clk);
      chk("rst pre gnt", 64'(gnt), 64'(2'b10));
      chk("rst pre rom", 64'(rom_addr), 64'(8'h77));
      req = 2'b00;
      #2 rst = 1'b1;
      #1;
      chk("rst gnt",      64'(gnt),      64'(2'b00));
      chk("rst rvalid",   64'(rvalid),   64'(1'b0));
      chk("rst rdata",    64'(rdata),    64'(35'h0));
      chk("rst busy",     64'(busy),     64'(1'b0));
      chk("rst rom_addr", 64'(rom_addr), 64'(8'h00));
      chk("rst rid",      64'(rid),      64'(1'b0));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post rst rvalid", 64'(rvalid), 64'(1'b0));
      chk("post rst busy",   64'(busy),   64'(1'b0));
      // After reset port 0 wins a tie.
      req = 2'b11; addr0 = 8'h12; addr1 = 8'h34;
      @(negedge clk);
      chk("post rst gnt", 64'(gnt), 64'(2'b01));
      chk("post rst rom", 64'(rom_addr), 64'(8'h12));
      req = 2'b00;
      @(negedge clk);
      chk("post rst rv", 64'({rvalid, rid}), 64'(2'b10));
      chk("post rst rdata", 64'(rdata), 64'(glyph(8'h12)));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
